// File: rtl/doce_tx_pkg.sv
// Shared encodings and field widths for the TX channel arbiter and its output slice.
package doce_tx_pkg;

  localparam int BYTE_NUM_W = 13;
  localparam int CONN_ID_W  = 4;

  localparam logic SRC_R = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_R_BURST = 2'd1,
    ST_B_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tx_out_slice.sv
// Single-entry registered output stage: one cycle latency, full throughput.
module tx_out_slice
  import doce_tx_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic [DATA_W/8-1:0]   in_keep_i,
  input  logic                  in_last_i,
  input  logic [CONN_ID_W-1:0]  in_conn_id_i,
  input  logic [BYTE_NUM_W-1:0] in_byte_num_i,
  input  logic                  in_src_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [DATA_W/8-1:0]   out_keep_o,
  output logic                  out_last_o,
  output logic [CONN_ID_W-1:0]  out_conn_id_o,
  output logic [BYTE_NUM_W-1:0] out_byte_num_o,
  output logic                  out_src_o
);

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W/8-1:0]   keep_q, keep_d;
  logic                  last_q, last_d;
  logic [CONN_ID_W-1:0]  conn_q, conn_d;
  logic [BYTE_NUM_W-1:0] bn_q, bn_d;
  logic                  src_q, src_d;

  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    conn_d  = conn_q;
    bn_d    = bn_q;
    src_d   = src_q;
    // Payload is held while stalled; it only changes when a new beat lands.
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
        keep_d = in_keep_i;
        last_d = in_last_i;
        conn_d = in_conn_id_i;
        bn_d   = in_byte_num_i;
        src_d  = in_src_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      conn_q  <= '0;
      bn_q    <= '0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      conn_q  <= conn_d;
      bn_q    <= bn_d;
      src_q   <= src_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign out_data_o     = data_q;
  assign out_keep_o     = keep_q;
  assign out_last_o     = last_q;
  assign out_conn_id_o  = conn_q;
  assign out_byte_num_o = bn_q;
  assign out_src_o      = src_q;

endmodule

// File: rtl/tx_channel_arbiter.sv
// Merges read (r) and write (b) response packets onto one TX stream, packet-atomic.
//   state      | meaning
//   ST_IDLE    | no packet open; arbitrate r vs b each cycle
//   ST_R_BURST | r packet open; only r accepted until its last beat
//   ST_B_BURST | b packet open; only b accepted until its last beat
module tx_channel_arbiter
  import doce_tx_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int RR_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     r_channel,
  input  logic [DATA_W/8-1:0]   r_channel_keep,
  input  logic                  r_channel_last,
  input  logic [CONN_ID_W-1:0]  r_channel_connection_id,
  input  logic [BYTE_NUM_W-1:0] r_channel_byte_num,
  input  logic                  r_channel_valid,
  output logic                  r_channel_ready,
  input  logic [DATA_W-1:0]     b_channel,
  input  logic [DATA_W/8-1:0]   b_channel_keep,
  input  logic                  b_channel_last,
  input  logic [CONN_ID_W-1:0]  b_channel_connection_id,
  input  logic [BYTE_NUM_W-1:0] b_channel_byte_num,
  input  logic                  b_channel_valid,
  output logic                  b_channel_ready,
  output logic [DATA_W-1:0]     tx_data,
  output logic [DATA_W/8-1:0]   tx_keep,
  output logic                  tx_last,
  output logic [CONN_ID_W-1:0]  tx_connection_id,
  output logic [BYTE_NUM_W-1:0] tx_byte_num,
  output logic                  tx_src,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [15:0]           r_pkt_cnt,
  output logic [15:0]           b_pkt_cnt,
  output logic                  err_b_multibeat
);

  arb_state_e  state_q, state_d;
  logic        last_src_q, last_src_d;
  logic [15:0] r_cnt_q, r_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;
  logic        err_q, err_d;

  logic        slice_ready;
  logic        r_pref;
  logic        r_acc, b_acc;
  logic        beat_valid;
  logic        grant_src;

  always_comb begin
    state_d         = state_q;
    last_src_d      = last_src_q;
    r_cnt_d         = r_cnt_q;
    b_cnt_d         = b_cnt_q;
    err_d           = err_q;
    r_channel_ready = 1'b0;
    b_channel_ready = 1'b0;
    // In a tie r wins only under round-robin when b was served last.
    r_pref          = (RR_EN != 0) && (last_src_q == SRC_B);

    // A source's ready is gated by the other source's valid, never its own.
    case (state_q)
      ST_IDLE: begin
        r_channel_ready = slice_ready & (~b_channel_valid | r_pref);
        b_channel_ready = slice_ready & (~r_channel_valid | ~r_pref);
      end
      ST_R_BURST: r_channel_ready = slice_ready;
      ST_B_BURST: b_channel_ready = slice_ready;
      default:    state_d = ST_IDLE;
    endcase

    if (reset) begin
      r_channel_ready = 1'b0;
      b_channel_ready = 1'b0;
    end

    r_acc      = r_channel_valid & r_channel_ready;
    b_acc      = b_channel_valid & b_channel_ready;
    beat_valid = r_acc | b_acc;
    grant_src  = b_acc ? SRC_B : SRC_R;

    if (r_acc) begin
      last_src_d = SRC_R;
      if (r_channel_last) begin
        state_d = ST_IDLE;
        r_cnt_d = r_cnt_q + 16'd1;
      end else begin
        state_d = ST_R_BURST;
      end
    end

    if (b_acc) begin
      last_src_d = SRC_B;
      if (b_channel_last) begin
        state_d = ST_IDLE;
        b_cnt_d = b_cnt_q + 16'd1;
      end else begin
        state_d = ST_B_BURST;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_src_q <= SRC_R;
      r_cnt_q    <= '0;
      b_cnt_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      r_cnt_q    <= r_cnt_d;
      b_cnt_q    <= b_cnt_d;
      err_q      <= err_d;
    end
  end

  tx_out_slice #(
    .DATA_W (DATA_W)
  ) u_out_slice (
    .clk            (clk),
    .reset          (reset),
    .in_valid_i     (beat_valid),
    .in_ready_o     (slice_ready),
    .in_data_i      (b_acc ? b_channel : r_channel),
    .in_keep_i      (b_acc ? b_channel_keep : r_channel_keep),
    .in_last_i      (b_acc ? b_channel_last : r_channel_last),
    .in_conn_id_i   (b_acc ? b_channel_connection_id : r_channel_connection_id),
    .in_byte_num_i  (b_acc ? b_channel_byte_num : r_channel_byte_num),
    .in_src_i       (grant_src),
    .out_valid_o    (tx_valid),
    .out_ready_i    (tx_ready),
    .out_data_o     (tx_data),
    .out_keep_o     (tx_keep),
    .out_last_o     (tx_last),
    .out_conn_id_o  (tx_connection_id),
    .out_byte_num_o (tx_byte_num),
    .out_src_o      (tx_src)
  );

  assign r_pkt_cnt       = r_cnt_q;
  assign b_pkt_cnt       = b_cnt_q;
  assign err_b_multibeat = err_q;

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Directed bench for tx_channel_arbiter with a per-cycle packet-level reference model.
module tb_tx_channel_arbiter;

  localparam int DW = 128;
  localparam int RR = 1;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [3:0]   conn;
    logic [12:0]  bn;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] r_channel, b_channel;
  logic [15:0]   r_channel_keep, b_channel_keep;
  logic          r_channel_last, b_channel_last;
  logic [3:0]    r_channel_connection_id, b_channel_connection_id;
  logic [12:0]   r_channel_byte_num, b_channel_byte_num;
  logic          r_channel_valid = 1'b0, b_channel_valid = 1'b0;
  logic          r_channel_ready, b_channel_ready;
  logic [DW-1:0] tx_data;
  logic [15:0]   tx_keep;
  logic          tx_last;
  logic [3:0]    tx_connection_id;
  logic [12:0]   tx_byte_num;
  logic          tx_src, tx_valid;
  logic          tx_ready = 1'b1;
  logic [15:0]   r_pkt_cnt, b_pkt_cnt;
  logic          err_b_multibeat;

  tx_channel_arbiter #(.DATA_W(DW), .RR_EN(RR)) dut (
    .clk(clk), .reset(reset),
    .r_channel(r_channel), .r_channel_keep(r_channel_keep), .r_channel_last(r_channel_last),
    .r_channel_connection_id(r_channel_connection_id), .r_channel_byte_num(r_channel_byte_num),
    .r_channel_valid(r_channel_valid), .r_channel_ready(r_channel_ready),
    .b_channel(b_channel), .b_channel_keep(b_channel_keep), .b_channel_last(b_channel_last),
    .b_channel_connection_id(b_channel_connection_id), .b_channel_byte_num(b_channel_byte_num),
    .b_channel_valid(b_channel_valid), .b_channel_ready(b_channel_ready),
    .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last), .tx_connection_id(tx_connection_id),
    .tx_byte_num(tx_byte_num), .tx_src(tx_src), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .r_pkt_cnt(r_pkt_cnt), .b_pkt_cnt(b_pkt_cnt), .err_b_multibeat(err_b_multibeat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Source queues, handshake flags and tx observations
  beat_t r_q[$];
  beat_t b_q[$];
  bit    r_fire = 1'b0, b_fire = 1'b0;
  int    tx_beats = 0;
  bit    log_q[$];

  // Reference model state
  int          m_owner;   // 0 none, 1 r packet open, 2 b packet open
  bit          m_tie_b;
  bit          m_ov;
  beat_t       m_out;
  bit          m_src;
  logic [15:0] m_rc, m_bc;
  bit          m_err;
  beat_t       r_in, b_in;

  initial begin : cmp
    bit can_take, rv, bv;
    int win;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_owner = 0; m_tie_b = 1'b1; m_ov = 1'b0; m_out = '0; m_src = 1'b0;
        m_rc = '0; m_bc = '0; m_err = 1'b0;
        r_fire = 1'b0; b_fire = 1'b0;
        chk("rst_r_ready", r_channel_ready, 0);
        chk("rst_b_ready", b_channel_ready, 0);
      end
      chk("tx_valid", tx_valid, m_ov);
      if (m_ov || reset)
        chk("tx_fields", {tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src},
            {m_out, m_src});
      chk("r_pkt_cnt", r_pkt_cnt, m_rc);
      chk("b_pkt_cnt", b_pkt_cnt, m_bc);
      chk("err_b_multibeat", err_b_multibeat, m_err);
      if (!reset) begin
        if (tx_valid && tx_ready) begin
          tx_beats++;
          if (tx_last) log_q.push_back(tx_src);
        end
        rv = r_channel_valid;
        bv = b_channel_valid;
        r_in = {r_channel, r_channel_keep, r_channel_last, r_channel_connection_id, r_channel_byte_num};
        b_in = {b_channel, b_channel_keep, b_channel_last, b_channel_connection_id, b_channel_byte_num};
        can_take = !m_ov || tx_ready;
        win = 0;
        if (m_owner == 1) begin
          if (rv) win = 1;
        end else if (m_owner == 2) begin
          if (bv) win = 2;
        end else if (rv && bv) win = (RR != 0 && !m_tie_b) ? 1 : 2;
        else if (rv) win = 1;
        else if (bv) win = 2;

        if (m_owner == 1) begin
          chk("burst_r_ready", r_channel_ready, can_take);
          chk("burst_b_ready_low", b_channel_ready, 0);
        end else if (m_owner == 2) begin
          chk("burst_b_ready", b_channel_ready, can_take);
          chk("burst_r_ready_low", r_channel_ready, 0);
        end else begin
          if (rv) chk("idle_r_ready", r_channel_ready, (win == 1) && can_take);
          if (bv) chk("idle_b_ready", b_channel_ready, (win == 2) && can_take);
        end
        r_fire = rv && r_channel_ready;
        b_fire = bv && b_channel_ready;

        if (can_take) begin
          m_ov = (win != 0);
          if (win == 1) begin
            m_out = r_in; m_src = 1'b0; m_tie_b = 1'b1;
            if (r_in.last) begin m_rc = m_rc + 16'd1; m_owner = 0; end
            else m_owner = 1;
          end else if (win == 2) begin
            m_out = b_in; m_src = 1'b1; m_tie_b = 1'b0;
            if (b_in.last) begin m_bc = m_bc + 16'd1; m_owner = 0; end
            else begin m_owner = 2; m_err = 1'b1; end
          end
        end
      end
    end
  end

  task automatic drive();
    beat_t rb, bb;
    rb = (r_q.size() != 0) ? r_q[0] : '0;
    bb = (b_q.size() != 0) ? b_q[0] : '0;
    r_channel_valid = (r_q.size() != 0);
    b_channel_valid = (b_q.size() != 0);
    {r_channel, r_channel_keep, r_channel_last, r_channel_connection_id, r_channel_byte_num} = rb;
    {b_channel, b_channel_keep, b_channel_last, b_channel_connection_id, b_channel_byte_num} = bb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (r_fire) void'(r_q.pop_front());
    if (b_fire) void'(b_q.pop_front());
    drive();
    #1;
  endtask

  task automatic push_pkt(input bit is_b, input int nbeats, input logic [3:0] conn,
                          input logic [12:0] bn, input int tag);
    beat_t bt;
    for (int i = 0; i < nbeats; i++) begin
      bt.data = {32'(tag), 32'(i), 32'hC0DE_0000 ^ 32'(tag), 32'(is_b)};
      bt.keep = 16'hFFFF >> (i % 4);
      bt.last = (i == nbeats - 1);
      bt.conn = conn;
      bt.bn   = bn;
      if (is_b) b_q.push_back(bt);
      else r_q.push_back(bt);
    end
    drive();
  endtask

  task automatic drain(input int max, output int used);
    bit busy;
    used = 0;
    busy = 1'b1;
    while (busy && used < max) begin
      busy = (r_q.size() != 0) || (b_q.size() != 0) || tx_valid;
      if (busy) begin step(); used++; end
    end
    busy = (r_q.size() != 0) || (b_q.size() != 0) || tx_valid;
    chk("drain_timeout", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_q.delete();
    b_q.delete();
    drive();
    #1;
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_tx_fields", {tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src}, 0);
    chk("async_rst_readys", {r_channel_ready, b_channel_ready}, 0);
    chk("async_rst_cnts", {r_pkt_cnt, b_pkt_cnt, err_b_multibeat}, 0);
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin : main
    int used, base;
    logic [191:0] snap;
    #2;
    do_reset();

    // r 3-beat packet, b idle
    base = tx_beats;
    push_pkt(1'b0, 3, 4'h5, 13'd48, 1);
    step();
    chk("t1_first_valid", tx_valid, 1);
    chk("t1_first_src", tx_src, 0);
    chk("t1_conn", tx_connection_id, 4'h5);
    chk("t1_byte_num", tx_byte_num, 13'd48);
    chk("t1_first_not_last", tx_last, 0);
    step();
    step();
    chk("t1_third_last", tx_last, 1);
    chk("t1_r_pkt_cnt", r_pkt_cnt, 16'd1);
    drain(20, used);
    chk("t1_beats", tx_beats - base, 3);

    // round-robin with both sources continuously valid
    do_reset();
    log_q.delete();
    push_pkt(1'b1, 1, 4'h1, 13'd4, 10);
    push_pkt(1'b1, 1, 4'h2, 13'd4, 11);
    push_pkt(1'b0, 2, 4'h3, 13'd32, 12);
    push_pkt(1'b0, 2, 4'h4, 13'd32, 13);
    drain(50, used);
    chk("t2_cycles_no_bubble", used, 7);
    chk("t2_order", {log_q.size() == 4, (log_q.size() == 4) ? {log_q[0], log_q[1], log_q[2], log_q[3]} : 4'h0},
        {1'b1, 4'b1010});

    // b arrives mid r-packet
    do_reset();
    push_pkt(1'b0, 4, 4'h6, 13'd64, 20);
    step();
    push_pkt(1'b1, 1, 4'h7, 13'd8, 21);
    #1;
    chk("t3_b_ready_beat2", b_channel_ready, 0);
    step();
    chk("t3_b_ready_beat3", b_channel_ready, 0);
    step();
    chk("t3_b_ready_beat4", b_channel_ready, 0);
    step();
    chk("t3_b_ready_after_last", b_channel_ready, 1);
    chk("t3_r_last_out", {tx_valid, tx_src, tx_last}, 3'b101);
    step();
    chk("t3_b_follows", {tx_valid, tx_src, tx_last}, 3'b111);
    drain(20, used);

    // tx_ready stall mid-packet
    do_reset();
    base = tx_beats;
    push_pkt(1'b0, 4, 4'h8, 13'd100, 30);
    step();
    push_pkt(1'b1, 1, 4'h9, 13'd2, 31);
    step();
    tx_ready = 1'b0;
    #1;
    snap = {tx_valid, tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src};
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_readys", {r_channel_ready, b_channel_ready}, 2'b00);
      step();
      chk("t4_stall_hold", {tx_valid, tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src}, snap);
    end
    tx_ready = 1'b1;
    drain(30, used);
    chk("t4_beats", tx_beats - base, 5);
    chk("t4_cnts", {r_pkt_cnt, b_pkt_cnt}, {16'd1, 16'd1});

    // b packet counter wrap and sticky multibeat error
    do_reset();
    for (int k = 0; k < 65537; k++) push_pkt(1'b1, 1, 4'(k), 13'(k), k);
    drain(70000, used);
    chk("t5_b_cnt_wrap", b_pkt_cnt, 16'd1);
    chk("t5_no_err", err_b_multibeat, 0);
    push_pkt(1'b1, 2, 4'hA, 13'd16, 40);
    drain(20, used);
    chk("t5_err_set", err_b_multibeat, 1);
    chk("t5_b_cnt", b_pkt_cnt, 16'd2);
    push_pkt(1'b0, 1, 4'hB, 13'd1, 41);
    drain(20, used);
    chk("t5_err_sticky", err_b_multibeat, 1);

    // reset in B_BURST
    do_reset();
    push_pkt(1'b1, 3, 4'hC, 13'd24, 50);
    push_pkt(1'b0, 1, 4'hD, 13'd4, 51);
    step();
    step();
    chk("t6_in_b_burst", {err_b_multibeat, tx_src}, 2'b11);
    do_reset();
    log_q.delete();
    base = tx_beats;
    push_pkt(1'b0, 1, 4'h1, 13'd4, 52);
    push_pkt(1'b1, 1, 4'h2, 13'd4, 53);
    drain(20, used);
    chk("t6_b_tie_after_rst", {log_q.size() == 2, (log_q.size() == 2) ? {log_q[0], log_q[1]} : 2'b00},
        3'b110);
    chk("t6_beats", tx_beats - base, 2);

    // reset in R_BURST
    do_reset();
    push_pkt(1'b0, 3, 4'hE, 13'd40, 60);
    step();
    step();
    do_reset();
    log_q.delete();
    base = tx_beats;
    push_pkt(1'b0, 1, 4'h3, 13'd4, 61);
    push_pkt(1'b1, 1, 4'h4, 13'd4, 62);
    drain(20, used);
    chk("t7_b_tie_after_rst", {log_q.size() == 2, (log_q.size() == 2) ? {log_q[0], log_q[1]} : 2'b00},
        3'b110);
    chk("t7_beats", tx_beats - base, 2);
    chk("t7_cnts", {r_pkt_cnt, b_pkt_cnt}, {16'd1, 16'd1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
